// File: rtl/ucode_sequencer.sv
// Microcode sequencer: owns the micro-PC, addresses a synchronous microcode ROM and
// resolves jump / dispatch / conditional / return-to-fetch next-address selection.
module ucode_sequencer #(
    parameter int WORD_W         = 44,
    parameter int UADDR_W        = 10,
    parameter int OPCODE_W       = 8,
    parameter int DISPATCH_SHIFT = 2,
    parameter int FETCH_ADDR     = 0,
    parameter int NFLAGS         = 4,
    parameter int SEL_LSB        = 28,
    parameter int NEXT_LSB       = 30,
    parameter int COND_LSB       = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                restart,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [NFLAGS-1:0]   flags,
    output logic [UADDR_W-1:0]  rom_addr,
    input  logic [WORD_W-1:0]   rom_data,
    output logic [WORD_W-1:0]   uword,
    output logic                uword_valid,
    output logic [UADDR_W-1:0]  upc,
    output logic                instr_done
);

    localparam int CI_W = $clog2(NFLAGS);
    localparam int DW   = (OPCODE_W + DISPATCH_SHIFT > UADDR_W) ? OPCODE_W + DISPATCH_SHIFT : UADDR_W;
    localparam logic [UADDR_W-1:0] FETCH_UADDR = UADDR_W'(FETCH_ADDR);

    localparam logic [1:0] SEL_JUMP     = 2'b00;
    localparam logic [1:0] SEL_DISPATCH = 2'b01;
    localparam logic [1:0] SEL_COND     = 2'b10;

    typedef enum logic {PRIME, RUN} state_t;

    state_t              state_reg, state_next;
    logic [UADDR_W-1:0]  upc_reg, upc_next;

    logic [1:0]          sel;
    logic [UADDR_W-1:0]  nxt;
    logic [CI_W-1:0]     ci;
    logic [UADDR_W-1:0]  dispatch_addr;
    logic [UADDR_W-1:0]  branch_addr;

    assign sel = rom_data[SEL_LSB +: 2];
    assign nxt = rom_data[NEXT_LSB +: UADDR_W];
    assign ci  = rom_data[COND_LSB +: CI_W];

    // Opcode is widened before shifting so high opcode bits fall off only at the final truncation
    assign dispatch_addr = UADDR_W'(DW'(opcode) << DISPATCH_SHIFT);

    always_comb begin
        case (sel)
            SEL_JUMP:     branch_addr = nxt;
            SEL_DISPATCH: branch_addr = dispatch_addr;
            SEL_COND:     branch_addr = flags[ci] ? nxt : upc_reg + UADDR_W'(1);
            default:      branch_addr = FETCH_UADDR;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        upc_next    = upc_reg;
        rom_addr    = FETCH_UADDR;
        uword       = '0;
        uword_valid = 1'b0;
        instr_done  = 1'b0;
        if (restart) begin
            upc_next   = FETCH_UADDR;
            state_next = RUN;
        end else if (state_reg == PRIME) begin
            // ROM output is not yet meaningful; spend one cycle fetching the first word
            upc_next   = FETCH_UADDR;
            state_next = RUN;
        end else if (stall) begin
            // Re-read the same address so rom_data keeps presenting the held word
            rom_addr = upc_reg;
        end else begin
            rom_addr    = branch_addr;
            upc_next    = branch_addr;
            uword       = rom_data;
            uword_valid = 1'b1;
            instr_done  = (sel == 2'b11);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= PRIME;
            upc_reg   <= FETCH_UADDR;
        end else begin
            state_reg <= state_next;
            upc_reg   <= upc_next;
        end
    end

    assign upc = upc_reg;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer with a behavioural synchronous ROM.
module tb_ucode_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        restart;
    logic [7:0]  opcode;
    logic [3:0]  flags;
    logic [9:0]  rom_addr;
    logic [43:0] rom_data = '0;
    logic [43:0] uword;
    logic        uword_valid;
    logic [9:0]  upc;
    logic        instr_done;

    logic [43:0] rom_mem [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    ucode_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .restart     (restart),
        .opcode      (opcode),
        .flags       (flags),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .uword       (uword),
        .uword_valid (uword_valid),
        .upc         (upc),
        .instr_done  (instr_done)
    );

    function automatic logic [43:0] mk(input logic [1:0] sel, input logic [9:0] nxt,
                                       input logic [1:0] ci, input logic [27:0] tag);
        logic [43:0] w;
        w = '0;
        w[27:0]  = tag;
        w[29:28] = sel;
        w[39:30] = nxt;
        w[41:40] = ci;
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic restart_pulse;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stall = 1'b0; restart = 1'b0; opcode = '0; flags = '0;
        tick(); tick(); #1;
        checks++; if (upc !== 10'h000) begin errors++; $display("FAIL reset_upc: got %h expected 000", upc); end
        checks++; if (rom_addr !== 10'h000) begin errors++; $display("FAIL reset_rom_addr: got %h expected 000", rom_addr); end
        checks++; if (uword !== 44'h0) begin errors++; $display("FAIL reset_uword: got %h expected 0", uword); end
        checks++; if (uword_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", uword_valid); end
        checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", instr_done); end
        tick();
        rst_n = 1'b1;
        stall = 1'b1;
        #1;
        checks++; if (uword_valid !== 1'b0) begin errors++; $display("FAIL prime_valid: got %b expected 0", uword_valid); end
        checks++; if (rom_addr !== 10'h000) begin errors++; $display("FAIL prime_rom_addr: got %h expected 000", rom_addr); end
        tick();
        stall = 1'b0;
        #1;
        $display("reset: PRIME done, upc=%h valid=%b", upc, uword_valid);
    endtask

    task automatic test_jump_fetch;
        logic [9:0] exp_upc [4];
        exp_upc = '{10'h000, 10'h005, 10'h000, 10'h005};
        for (int i = 0; i < 4; i++) begin
            checks++; if (upc !== exp_upc[i]) begin errors++; $display("FAIL jump_upc[%0d]: got %h expected %h", i, upc, exp_upc[i]); end
            checks++; if (uword_valid !== 1'b1) begin errors++; $display("FAIL jump_valid[%0d]: got %b expected 1", i, uword_valid); end
            checks++; if (uword !== rom_mem[exp_upc[i]]) begin errors++; $display("FAIL jump_uword[%0d]: got %h expected %h", i, uword, rom_mem[exp_upc[i]]); end
            checks++; if (instr_done !== (exp_upc[i] == 10'h005)) begin errors++; $display("FAIL jump_done[%0d]: got %b expected %b", i, instr_done, exp_upc[i] == 10'h005); end
            $display("jump: cycle %0d upc=%h uword=%h done=%b", i, upc, uword, instr_done);
            tick(); #1;
        end
    endtask

    task automatic test_stall;
        int done_cnt;
        done_cnt = 0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (upc !== 10'h005) begin errors++; $display("FAIL stall_upc[%0d]: got %h expected 005", i, upc); end
            checks++; if (uword_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 0", i, uword_valid); end
            checks++; if (uword !== 44'h0) begin errors++; $display("FAIL stall_uword[%0d]: got %h expected 0", i, uword); end
            checks++; if (rom_addr !== 10'h005) begin errors++; $display("FAIL stall_rom_addr[%0d]: got %h expected 005", i, rom_addr); end
            done_cnt += int'(instr_done);
            $display("stall: cycle %0d upc=%h rom_addr=%h valid=%b", i, upc, rom_addr, uword_valid);
            tick();
        end
        stall = 1'b0;
        #1;
        checks++; if (uword !== rom_mem[5]) begin errors++; $display("FAIL stall_release_uword: got %h expected %h", uword, rom_mem[5]); end
        checks++; if (rom_addr !== 10'h000) begin errors++; $display("FAIL stall_release_rom_addr: got %h expected 000", rom_addr); end
        done_cnt += int'(instr_done);
        tick(); #1;
        checks++; if (upc !== 10'h000) begin errors++; $display("FAIL stall_after_upc: got %h expected 000", upc); end
        done_cnt += int'(instr_done);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
        $display("stall: released, instr_done pulses=%0d", done_cnt);
    endtask

    task automatic test_dispatch;
        rom_mem[0]     = mk(2'b01, 10'h000, 2'd0, 28'h00D1);
        rom_mem[10'h04C] = mk(2'b11, 10'h000, 2'd0, 28'h004C);
        rom_mem[10'h3FC] = mk(2'b11, 10'h000, 2'd0, 28'h03FC);
        opcode = 8'h13;
        restart_pulse();
        checks++; if (uword !== rom_mem[0]) begin errors++; $display("FAIL disp_uword: got %h expected %h", uword, rom_mem[0]); end
        checks++; if (rom_addr !== 10'h04C) begin errors++; $display("FAIL disp_rom_addr_13: got %h expected 04c", rom_addr); end
        tick(); #1;
        checks++; if (upc !== 10'h04C) begin errors++; $display("FAIL disp_upc_13: got %h expected 04c", upc); end
        checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL disp_done: got %b expected 1", instr_done); end
        $display("dispatch: opcode=13 upc=%h", upc);
        opcode = 8'hFF;
        restart_pulse();
        checks++; if (rom_addr !== 10'h3FC) begin errors++; $display("FAIL disp_rom_addr_ff: got %h expected 3fc", rom_addr); end
        tick(); #1;
        checks++; if (upc !== 10'h3FC) begin errors++; $display("FAIL disp_upc_ff: got %h expected 3fc", upc); end
        $display("dispatch: opcode=ff upc=%h", upc);
    endtask

    task automatic test_cond;
        rom_mem[0]       = mk(2'b00, 10'h010, 2'd0, 28'h0A00);
        rom_mem[10'h010] = mk(2'b10, 10'h020, 2'd2, 28'h0010);
        rom_mem[10'h020] = mk(2'b11, 10'h000, 2'd0, 28'h0020);
        rom_mem[10'h011] = mk(2'b11, 10'h000, 2'd0, 28'h0011);
        flags = 4'b0100;
        restart_pulse();
        tick(); #1;
        checks++; if (upc !== 10'h010) begin errors++; $display("FAIL cond_upc_10: got %h expected 010", upc); end
        checks++; if (rom_addr !== 10'h020) begin errors++; $display("FAIL cond_taken_addr: got %h expected 020", rom_addr); end
        tick(); #1;
        checks++; if (upc !== 10'h020) begin errors++; $display("FAIL cond_taken_upc: got %h expected 020", upc); end
        $display("cond: flags=0100 -> upc=%h", upc);
        flags = 4'b1011;
        restart_pulse();
        tick(); #1;
        checks++; if (rom_addr !== 10'h011) begin errors++; $display("FAIL cond_fall_addr: got %h expected 011", rom_addr); end
        tick(); #1;
        checks++; if (upc !== 10'h011) begin errors++; $display("FAIL cond_fall_upc: got %h expected 011", upc); end
        $display("cond: flags=1011 -> upc=%h", upc);
        rom_mem[0]       = mk(2'b00, 10'h3FF, 2'd0, 28'h0B00);
        rom_mem[10'h3FF] = mk(2'b10, 10'h020, 2'd2, 28'h03FF);
        flags = 4'b0000;
        restart_pulse();
        tick(); #1;
        checks++; if (upc !== 10'h3FF) begin errors++; $display("FAIL cond_wrap_src: got %h expected 3ff", upc); end
        checks++; if (rom_addr !== 10'h000) begin errors++; $display("FAIL cond_wrap_addr: got %h expected 000", rom_addr); end
        tick(); #1;
        checks++; if (upc !== 10'h000) begin errors++; $display("FAIL cond_wrap_upc: got %h expected 000", upc); end
        $display("cond: wrap 3ff -> upc=%h", upc);
        rom_mem[0] = mk(2'b00, 10'h010, 2'd0, 28'h0A00);
    endtask

    task automatic test_restart_stall;
        flags = 4'b0100;
        restart_pulse();
        tick(); tick(); #1;
        checks++; if (upc !== 10'h020) begin errors++; $display("FAIL rs_setup_upc: got %h expected 020", upc); end
        stall = 1'b1;
        restart = 1'b1;
        #1;
        checks++; if (uword_valid !== 1'b0) begin errors++; $display("FAIL rs_valid: got %b expected 0", uword_valid); end
        checks++; if (rom_addr !== 10'h000) begin errors++; $display("FAIL rs_rom_addr: got %h expected 000", rom_addr); end
        checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL rs_done: got %b expected 0", instr_done); end
        tick();
        restart = 1'b0;
        stall = 1'b0;
        #1;
        checks++; if (upc !== 10'h000) begin errors++; $display("FAIL rs_upc: got %h expected 000", upc); end
        checks++; if (uword_valid !== 1'b1) begin errors++; $display("FAIL rs_run_valid: got %b expected 1", uword_valid); end
        checks++; if (uword !== rom_mem[0]) begin errors++; $display("FAIL rs_uword: got %h expected %h", uword, rom_mem[0]); end
        $display("restart+stall: upc=%h valid=%b uword=%h", upc, uword_valid, uword);
    endtask

    task automatic test_reset_midstream;
        flags = 4'b1011;
        tick(); tick(); #1;
        checks++; if (upc !== 10'h011) begin errors++; $display("FAIL mr_setup_upc: got %h expected 011", upc); end
        rst_n = 1'b0;
        #1;
        checks++; if (upc !== 10'h000) begin errors++; $display("FAIL mr_upc: got %h expected 000", upc); end
        checks++; if (rom_addr !== 10'h000) begin errors++; $display("FAIL mr_rom_addr: got %h expected 000", rom_addr); end
        checks++; if (uword_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b expected 0", uword_valid); end
        checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL mr_done: got %b expected 0", instr_done); end
        tick();
        rst_n = 1'b1;
        stall = 1'b1;
        #1;
        checks++; if (uword_valid !== 1'b0) begin errors++; $display("FAIL mr_prime_valid: got %b expected 0", uword_valid); end
        tick();
        stall = 1'b0;
        #1;
        checks++; if (uword_valid !== 1'b1) begin errors++; $display("FAIL mr_run_valid: got %b expected 1", uword_valid); end
        checks++; if (uword !== rom_mem[0]) begin errors++; $display("FAIL mr_uword: got %h expected %h", uword, rom_mem[0]); end
        checks++; if (rom_addr !== 10'h010) begin errors++; $display("FAIL mr_next_addr: got %h expected 010", rom_addr); end
        $display("mid-stream reset: resumed upc=%h rom_addr=%h", upc, rom_addr);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = '0;
        rom_mem[0] = mk(2'b00, 10'h005, 2'd0, 28'h0AAA);
        rom_mem[5] = mk(2'b11, 10'h000, 2'd0, 28'h0BBB);
        test_reset();
        test_jump_fetch();
        test_stall();
        test_dispatch();
        test_cond();
        test_restart_stall();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
